// File: rtl/ihex_loader_pkg.sv
// Shared types and helpers for the Intel-HEX bus loader: FSM states, error codes,
// record-type constants and the ASCII hex nibble decoder.
package ihex_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, COUNT, ADDR, TYPE, DATA, CKSUM, WRITE, DONE
  } ihex_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HEX   = 2'd1,
    ERR_CKSUM = 2'd2,
    ERR_LEN   = 2'd3
  } ihex_err_t;

  localparam logic [7:0] IHEX_DATA  = 8'h00;
  localparam logic [7:0] IHEX_EOF   = 8'h01;
  localparam logic [7:0] IHEX_COLON = 8'h3A;

  // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

endpackage

// File: rtl/ihex_byte_assembler.sv
// Pairs hex nibbles into bytes (high nibble first) and keeps the mod-256 running
// sum of completed bytes; clear restarts both at the start of each record.
module ihex_byte_assembler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       nib_valid,
  input  logic [3:0] nib,
  output logic       byte_done,
  output logic [7:0] byte_val,
  output logic [7:0] sum_next
);

  logic       half_reg;
  logic [3:0] hi_reg;
  logic [7:0] sum_reg;

  assign byte_done = nib_valid & half_reg;
  assign byte_val  = {hi_reg, nib};
  assign sum_next  = sum_reg + byte_val;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      half_reg <= 1'b0;
      hi_reg   <= 4'd0;
      sum_reg  <= 8'd0;
    end else if (nib_valid) begin
      if (!half_reg) begin
        hi_reg   <= nib;
        half_reg <= 1'b1;
      end else begin
        half_reg <= 1'b0;
        sum_reg  <= sum_next;
      end
    end
  end

endmodule

// File: rtl/ihex_bus_loader.sv
// Intel-HEX loader: parses ASCII records (word-addressed, 4 bytes per word, MSB first)
// and, once the checksum is validated, writes the buffered words out as a bus initiator.
module ihex_bus_loader
  import ihex_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_BYTES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic        bus_ren,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  input  logic        bus_busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_written
);

  localparam int NWORDS = MAX_BYTES / 4;

  ihex_state_t state_reg, state_next;
  ihex_err_t   err_code_reg, err_next;
  logic        set_err;
  logic [7:0]  count_reg, type_reg, byte_idx_reg, word_idx_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_buf_reg [MAX_BYTES];
  logic        done_reg, error_reg;
  logic [15:0] words_reg;

  logic       hex_ok, accept, in_field, start, nib_stb, bad_char;
  logic [3:0] nib;
  logic       byte_done, write_ack, last_word;
  logic [7:0] byte_val, sum_next;

  assign {hex_ok, nib} = hex_nibble(rx_data);
  assign rx_ready  = ~RST & (state_reg != WRITE);
  assign accept    = rx_valid & rx_ready;
  assign in_field  = state_reg inside {COUNT, ADDR, TYPE, DATA, CKSUM};
  assign start     = accept & (state_reg == IDLE) & (rx_data == IHEX_COLON);
  assign nib_stb   = accept & in_field & hex_ok;
  assign bad_char  = accept & in_field & ~hex_ok;
  assign write_ack = (state_reg == WRITE) & ~bus_busy;
  assign last_word = word_idx_reg == ({2'b00, count_reg[7:2]} - 8'd1);

  ihex_byte_assembler u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (start),
    .nib_valid (nib_stb),
    .nib       (nib),
    .byte_done (byte_done),
    .byte_val  (byte_val),
    .sum_next  (sum_next)
  );

  always_comb begin
    state_next = state_reg;
    set_err    = 1'b0;
    err_next   = ERR_NONE;
    case (state_reg)
      IDLE:  if (start) state_next = COUNT;
      COUNT: if (byte_done) begin
        // Anything that cannot fit whole words in the buffer is rejected up front.
        if (byte_val[1:0] != 2'b00 || int'(byte_val) > MAX_BYTES) begin
          state_next = IDLE; set_err = 1'b1; err_next = ERR_LEN;
        end else state_next = ADDR;
      end
      ADDR:  if (byte_done && byte_idx_reg == 8'd1) state_next = TYPE;
      TYPE:  if (byte_done) begin
        if ((byte_val == IHEX_DATA && count_reg == 8'd0) ||
            (byte_val == IHEX_EOF && count_reg != 8'd0)) begin
          state_next = IDLE; set_err = 1'b1; err_next = ERR_LEN;
        end else state_next = (count_reg == 8'd0) ? CKSUM : DATA;
      end
      DATA:  if (byte_done && byte_idx_reg == count_reg - 8'd1) state_next = CKSUM;
      CKSUM: if (byte_done) begin
        if (sum_next != 8'd0) begin
          state_next = IDLE; set_err = 1'b1; err_next = ERR_CKSUM;
        end else if (type_reg == IHEX_DATA) state_next = WRITE;
        else if (type_reg == IHEX_EOF)      state_next = DONE;
        else                                state_next = IDLE;
      end
      WRITE: if (write_ack && last_word) state_next = IDLE;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (bad_char) begin
      state_next = IDLE; set_err = 1'b1; err_next = ERR_HEX;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      err_code_reg <= ERR_NONE;
      count_reg    <= 8'd0;
      type_reg     <= 8'd0;
      addr_reg     <= 16'd0;
      byte_idx_reg <= 8'd0;
      word_idx_reg <= 8'd0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      words_reg    <= 16'd0;
      for (int i = 0; i < MAX_BYTES; i++) data_buf_reg[i] <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) byte_idx_reg <= 8'd0;
      else if (byte_done)          byte_idx_reg <= byte_idx_reg + 8'd1;
      if (byte_done) begin
        case (state_reg)
          COUNT: count_reg <= byte_val;
          ADDR:  addr_reg  <= {addr_reg[7:0], byte_val};
          TYPE:  type_reg  <= byte_val;
          DATA:  for (int i = 0; i < MAX_BYTES; i++)
                   if (int'(byte_idx_reg) == i) data_buf_reg[i] <= byte_val;
          default: ;
        endcase
      end
      if (state_reg != WRITE) word_idx_reg <= 8'd0;
      else if (write_ack)     word_idx_reg <= word_idx_reg + 8'd1;
      if (write_ack && words_reg != 16'hFFFF) words_reg <= words_reg + 16'd1;
      if (set_err) begin
        error_reg    <= 1'b1;
        err_code_reg <= err_next;
      end
      if (state_next == DONE) done_reg <= 1'b1;
    end
  end

  always_comb begin
    bus_wdata = 32'd0;
    if (state_reg == WRITE)
      for (int i = 0; i < NWORDS; i++)
        if (int'(word_idx_reg) == i)
          bus_wdata = {data_buf_reg[4*i], data_buf_reg[4*i+1],
                       data_buf_reg[4*i+2], data_buf_reg[4*i+3]};
  end

  assign bus_wen     = (state_reg == WRITE);
  assign bus_ren     = 1'b0;
  assign bus_byte_en = 4'hf;
  assign bus_addr    = (state_reg == WRITE)
                     ? BASE_ADDR + {14'd0, addr_reg, 2'b00} + {22'd0, word_idx_reg, 2'b00}
                     : 32'd0;
  assign done          = done_reg;
  assign error         = error_reg;
  assign err_code      = err_code_reg;
  assign words_written = words_reg;

endmodule

// File: tb/tb_ihex_bus_loader.sv
// Bench for ihex_bus_loader: directed records plus randomized records, each checked
// against a record-level reference model of the loader's externally visible behaviour.
module tb_ihex_bus_loader;

  localparam int          MAXB = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_wen, bus_ren;
  logic [3:0]  bus_byte_en;
  logic        bus_busy = 1'b0;
  logic        done, error;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  ihex_bus_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_wdata(bus_wdata),
    .bus_byte_en(bus_byte_en), .bus_busy(bus_busy), .done(done), .error(error),
    .err_code(err_code), .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int m_err = 0, m_words = 0;
  bit m_error = 0, m_done = 0;

  // Bus slave: optionally stalls the first busy_left cycles of a record's writes.
  int busy_left = 0;
  int wen_cycles = 0;
  always @(posedge CLK) begin
    #1;
    if (bus_wen && busy_left > 0) begin
      bus_busy = 1'b1;
      busy_left--;
    end else bus_busy = 1'b0;
  end

  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
  always @(negedge CLK) begin
    if (!RST && bus_wen) begin
      wen_cycles++;
      check("byte_en", 32'(bus_byte_en), 32'hf);
      check("rx_ready_in_write", 32'(rx_ready), 32'd0);
      check("ren", 32'(bus_ren), 32'd0);
      if (prev_hold) begin
        check("addr_hold", bus_addr, prev_addr);
        check("wdata_hold", bus_wdata, prev_wdata);
      end
      if (!bus_busy) obs_q.push_back({bus_addr, bus_wdata});
    end
    prev_hold  = !RST && bus_wen && bus_busy;
    prev_addr  = bus_addr;
    prev_wdata = bus_wdata;
  end

  function automatic int hexv(input logic [7:0] c);
    if (c >= 8'd48 && c <= 8'd57)  return int'(c) - 48;
    if (c >= 8'd65 && c <= 8'd70)  return int'(c) - 55;
    if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
    return -1;
  endfunction

  function automatic void fail_rec(input int code);
    m_err   = code;
    m_error = 1'b1;
  endfunction

  // Record-level interpretation of the loader rules.
  function automatic void model(input string s);
    int p, hi, lo, bad_at, cnt, typ, sum;
    int bytes[$];
    logic [31:0] a32;
    if (m_done) return;
    p = 0;
    while (p < s.len() && s[p] != ":") p++;
    if (p >= s.len()) return;
    p++;
    bad_at = -1;
    for (; p < s.len(); p += 2) begin
      hi = hexv(s[p]);
      lo = (p + 1 < s.len()) ? hexv(s[p+1]) : -1;
      if (hi < 0 || lo < 0) begin bad_at = bytes.size(); break; end
      bytes.push_back(hi * 16 + lo);
    end
    if (bad_at == 0) begin fail_rec(1); return; end
    cnt = bytes[0];
    if (cnt % 4 != 0 || cnt > MAXB) begin fail_rec(3); return; end
    if (bad_at >= 0 && bad_at < 4) begin fail_rec(1); return; end
    typ = bytes[3];
    if ((typ == 0 && cnt == 0) || (typ == 1 && cnt != 0)) begin fail_rec(3); return; end
    if (bad_at >= 0 && bad_at < 5 + cnt) begin fail_rec(1); return; end
    sum = 0;
    for (int i = 0; i < 5 + cnt; i++) sum += bytes[i];
    if (sum % 256 != 0) begin fail_rec(2); return; end
    if (typ == 1) m_done = 1'b1;
    else if (typ == 0) begin
      for (int w = 0; w < cnt / 4; w++) begin
        a32 = BASE + (32'(bytes[1] * 256 + bytes[2]) << 2) + 32'(4 * w);
        exp_q.push_back({a32, 8'(bytes[4+4*w]), 8'(bytes[5+4*w]),
                         8'(bytes[6+4*w]), 8'(bytes[7+4*w])});
        m_words++;
      end
    end
  endfunction

  function automatic string mk_rec(input int cnt, input logic [15:0] a, input logic [7:0] t,
                                   input logic [7:0] d[$], input logic [7:0] ck_err,
                                   input bit lower);
    logic [7:0] bs[$];
    logic [7:0] sum;
    string s;
    bs = {8'(cnt), a[15:8], a[7:0], t};
    foreach (d[i]) bs.push_back(d[i]);
    sum = 8'd0;
    foreach (bs[i]) sum += bs[i];
    bs.push_back(8'(8'd0 - sum) + ck_err);
    s = ":";
    foreach (bs[i]) s = {s, lower ? $sformatf("%02x", bs[i]) : $sformatf("%02X", bs[i])};
    return s;
  endfunction

  task automatic send_char(input logic [7:0] c);
    int t;
    t = 0;
    @(negedge CLK);
    while (!rx_ready && t < 200) begin @(negedge CLK); t++; end
    if (!rx_ready) begin
      check("rx_ready_wait", 32'(rx_ready), 32'd1);
      return;
    end
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_record(input string tag, input string s, input int busy);
    logic [63:0] o, e;
    int nw_obs, nw_exp;
    busy_left  = busy;
    wen_cycles = 0;
    model(s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(8'h0A);
    @(negedge CLK);
    nw_obs = obs_q.size();
    nw_exp = exp_q.size();
    check({tag, "_nwrites"}, 32'(nw_obs), 32'(nw_exp));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_addr"}, o[63:32], e[63:32]);
      check({tag, "_wdata"}, o[31:0], e[31:0]);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_error"}, 32'(error), 32'(m_error));
    check({tag, "_err_code"}, 32'(err_code), 32'(m_err));
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_words"}, 32'(words_written), 32'(m_words));
    $display("rec %-8s %-40s writes=%0d err=%0d done=%0d words=%0d",
             tag, s, nw_obs, err_code, done, words_written);
  endtask

  initial begin
    int kind, cnt, busy, pos;
    logic [15:0] a;
    logic [7:0] t, ck_err;
    logic [7:0] d[$];
    bit lower;
    string s;

    repeat (2) @(negedge CLK);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_wen", 32'(bus_wen), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_byte_en", 32'(bus_byte_en), 32'hf);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    run_record("plan1", ":0400400012345678A8", 0);
    check("plan1_const_words", 32'(words_written), 32'd1);
    run_record("plan2", ":08004100AABBCCDD11223344FF", 0);
    run_record("busy3", ":0400400012345678A8", 3);
    check("busy3_wen_cycles", 32'(wen_cycles), 32'd4);
    run_record("badck", ":0400400012345678A9", 0);
    check("badck_code_const", 32'(err_code), 32'd2);
    run_record("recover", ":0400400012345678A8", 0);
    run_record("badlen", ":03004000123456A0", 0);
    run_record("badchar", ":04004000123G5678A8", 0);

    for (int r = 0; r < 40; r++) begin
      kind   = $urandom_range(0, 9);
      cnt    = 4 * $urandom_range(1, MAXB / 4);
      a      = 16'($urandom);
      t      = 8'h00;
      ck_err = 8'd0;
      lower  = 1'($urandom_range(0, 1));
      busy   = $urandom_range(0, 3);
      if (kind == 5) ck_err = 8'($urandom_range(1, 255));
      if (kind == 6) cnt = $urandom_range(0, 1) ? $urandom_range(1, 3) : MAXB + 4;
      if (kind == 8) t = 8'h05;
      if (kind == 9) cnt = 0;
      d.delete();
      for (int i = 0; i < cnt; i++) d.push_back(8'($urandom));
      s = mk_rec(cnt, a, t, d, ck_err, lower);
      if (kind == 7) begin
        pos = $urandom_range(1, s.len() - 1);
        s.putc(pos, $urandom_range(0, 1) ? "G" : "/");
      end
      run_record($sformatf("rnd%0d", r), s, busy);
    end

    run_record("eof", ":00000001FF", 0);
    run_record("post_eof", ":0400400012345678A8", 0);
    check("done_sticky", 32'(done), 32'd1);

    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst2_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    m_done = 1'b0; m_error = 1'b0; m_err = 0; m_words = 0;
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_error", 32'(error), 32'd0);
    check("rst2_err_code", 32'(err_code), 32'd0);
    check("rst2_words", 32'(words_written), 32'd0);
    run_record("after_rst", ":0400400012345678A8", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
